// File: rtl/cr_ram_rd_stream_if.sv
// RAM read port plus output stream of the read sequencer.
// master = sequencer side, slave = RAM/consumer side.
interface cr_ram_rd_stream_if #(
  parameter int pWidth    = 8,
  parameter int pAddrSize = 4
);
  logic                 RdEn;
  logic [pAddrSize-1:0] RdAddr;
  logic [pWidth-1:0]    RdData;
  logic                 OutValid;
  logic                 OutReady;
  logic [pWidth-1:0]    OutData;
  logic                 OutLast;

  modport master (
    output RdEn, RdAddr, OutValid, OutData, OutLast,
    input  RdData, OutReady
  );

  modport slave (
    input  RdEn, RdAddr, OutValid, OutData, OutLast,
    output RdData, OutReady
  );
endinterface

// File: rtl/cr_ram_rd_stream.sv
// Streams Length consecutive words out of a 1-cycle-latency synchronous RAM
// onto a valid/ready port, with a 2-entry buffer covering latency and stalls.
module cr_ram_rd_stream #(
  parameter int pWidth    = 8,
  parameter int pAddrSize = 4
) (
  input  logic                 Clk,
  input  logic                 RstN,
  input  logic                 Start,
  input  logic [pAddrSize-1:0] BaseAddr,
  input  logic [pAddrSize:0]   Length,
  output logic                 Busy,
  output logic                 Done,
  cr_ram_rd_stream_if.master   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [pAddrSize:0] kOne = (pAddrSize + 1)'(1);

  state_t               state_q, state_d;
  logic [pAddrSize-1:0] addr_q, addr_d;
  logic [pAddrSize:0]   rem_issue_q, rem_issue_d;
  logic [pAddrSize:0]   rem_out_q, rem_out_d;
  logic                 inflight_q, inflight_d;
  logic [1:0]           occ_q, occ_d;
  logic [pWidth-1:0]    buf0_q, buf0_d;
  logic [pWidth-1:0]    buf1_q, buf1_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 pop;
  logic                 issue;
  logic [2:0]           backlog;
  logic [1:0]           occ_after_pop;

  // Backlog counts buffered words plus the read in flight, net of this cycle's pop;
  // a new read is only allowed if its data is guaranteed a free buffer slot.
  always_comb begin
    pop     = (occ_q != 2'd0) && bus.OutReady;
    backlog = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue   = (state_q == RUN) && (rem_issue_q != '0) && (backlog < 3'd2);
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    rem_issue_d   = rem_issue_q;
    rem_out_d     = rem_out_q;
    inflight_d    = issue;
    occ_after_pop = occ_q - {1'b0, pop};
    buf0_d        = pop ? buf1_q : buf0_q;
    buf1_d        = buf1_q;
    occ_d         = occ_after_pop;

    if (inflight_q) begin
      if (occ_after_pop == 2'd0) begin
        buf0_d = bus.RdData;
      end else begin
        buf1_d = bus.RdData;
      end
      occ_d = occ_after_pop + 2'd1;
    end

    if (issue) begin
      addr_d      = addr_q + 1'b1;
      rem_issue_d = rem_issue_q - kOne;
    end

    if (pop) begin
      rem_out_d = rem_out_q - kOne;
    end

    case (state_q)
      IDLE: begin
        if (Start) begin
          addr_d      = BaseAddr;
          rem_issue_d = Length;
          rem_out_d   = Length;
          state_d     = (Length != '0) ? RUN : FIN;
        end
      end
      RUN: begin
        if (pop && (rem_out_q == kOne)) begin
          state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == FIN);
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rem_issue_q <= '0;
      rem_out_q   <= '0;
      inflight_q  <= 1'b0;
      occ_q       <= 2'd0;
      buf0_q      <= '0;
      buf1_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_issue_q <= rem_issue_d;
      rem_out_q   <= rem_out_d;
      inflight_q  <= inflight_d;
      occ_q       <= occ_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.RdEn     = issue;
  assign bus.RdAddr   = addr_q;
  assign bus.OutValid = (occ_q != 2'd0);
  assign bus.OutData  = buf0_q;
  assign bus.OutLast  = (occ_q != 2'd0) && (rem_out_q == kOne);
  assign Busy         = busy_q;
  assign Done         = done_q;

endmodule

// File: tb/tb_cr_ram_rd_stream.sv
// Bench for cr_ram_rd_stream: vector table, reset-in-flight sequence and random
// transfers, all scored against a queue model of the words each transfer should deliver.
module tb_cr_ram_rd_stream;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] base_addr;
  logic [4:0] length;
  logic       busy;
  logic       done;

  logic [7:0] mem [16];
  logic [7:0] ram_q;

  int checks;
  int failures;

  cr_ram_rd_stream_if #(.pWidth(8), .pAddrSize(4)) bus ();

  cr_ram_rd_stream #(.pWidth(8), .pAddrSize(4)) dut (
    .Clk      (clk),
    .RstN     (rst_n),
    .Start    (start),
    .BaseAddr (base_addr),
    .Length   (length),
    .Busy     (busy),
    .Done     (done),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.RdEn) ram_q <= mem[bus.RdAddr];
  end
  assign bus.RdData = ram_q;

  typedef struct {
    string      name;
    int         base;
    int         len;
    logic [15:0] pat;
    bit         restart;
    int         exp_done;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_rden"},     int'(bus.RdEn),     0);
    chk({nm, "_rdaddr"},   int'(bus.RdAddr),   0);
    chk({nm, "_outvalid"}, int'(bus.OutValid), 0);
    chk({nm, "_outdata"},  int'(bus.OutData),  0);
    chk({nm, "_outlast"},  int'(bus.OutLast),  0);
    chk({nm, "_busy"},     int'(busy),         0);
    chk({nm, "_done"},     int'(done),         0);
  endtask

  // exp_done > 0 additionally pins the exact Busy/Done timeline.
  task automatic run_xfer(input string nm, input int base, input int len,
                          input logic [15:0] pat, input bit restart, input int exp_done);
    logic [7:0] q [$];
    int   issued, popped, done_cyc, first_v, c;
    bit   held, pop_now;
    logic [7:0] held_d;
    issued = 0; popped = 0; done_cyc = -1; first_v = -1; held = 0; held_d = '0;
    for (int i = 0; i < len; i++) q.push_back(mem[4'((base + i) % 16)]);
    c = 0;
    while (done_cyc < 0 && c < 1000) begin
      @(negedge clk);
      start        = (c == 0) || (restart && c == 2);
      base_addr    = (c == 0) ? 4'(base) : 4'd9;
      length       = (c == 0) ? 5'(len)  : 5'd7;
      bus.OutReady = pat[c[3:0]];
      #1;
      pop_now = bus.OutValid && bus.OutReady;
      if (held) begin
        chk({nm, "_stall_valid"}, int'(bus.OutValid), 1);
        chk({nm, "_stall_data"},  int'(bus.OutData),  int'(held_d));
      end
      held   = bus.OutValid && !bus.OutReady;
      held_d = bus.OutData;
      if (bus.OutValid && first_v < 0) first_v = c;
      chk({nm, "_last"}, int'(bus.OutLast), int'(bus.OutValid && q.size() == 1));
      if (pop_now) begin
        if (q.size() == 0) chk({nm, "_extra_word"}, 1, 0);
        else               chk({nm, "_data"}, int'(bus.OutData), int'(q.pop_front()));
        popped++;
      end
      if (bus.RdEn) begin
        chk({nm, "_rdaddr"},     int'(bus.RdAddr), (base + issued) % 16);
        chk({nm, "_over_issue"}, int'(issued < len), 1);
        chk({nm, "_backlog"},    int'((issued - popped) < 2), 1);
        issued++;
      end
      chk({nm, "_busy_done_excl"}, int'(busy && done), 0);
      if (exp_done > 0) begin
        chk({nm, "_busy"}, int'(busy), int'(len != 0 && c >= 1 && c < exp_done));
        chk({nm, "_done"}, int'(done), int'(c == exp_done));
      end
      if (done) done_cyc = c;
      c++;
    end
    start = 1'b0;
    if (done_cyc < 0) begin
      chk({nm, "_timeout"}, 0, 1);
    end else begin
      chk({nm, "_words_left"}, q.size(), 0);
      chk({nm, "_issued"},     issued,   len);
      chk({nm, "_popped"},     popped,   len);
      if (exp_done > 0) chk({nm, "_done_cycle"}, done_cyc, exp_done);
      if (len == 0)          chk({nm, "_first_valid"}, first_v, -1);
      else if (exp_done > 0) chk({nm, "_first_valid"}, first_v, 3);
    end
  endtask

  initial begin
    int pops;
    checks = 0; failures = 0;
    clk = 1'b0; rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0;
    bus.OutReady = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 8'hA0 + 8'(i);

    vecs[0] = '{"basic4",    0,  4, 16'hFFFF, 1'b0, 7};
    vecs[1] = '{"stall4",    0,  4, 16'h9999, 1'b0, 0};
    vecs[2] = '{"wrap4",     14, 4, 16'hFFFF, 1'b0, 7};
    vecs[3] = '{"len0",      3,  0, 16'hFFFF, 1'b0, 1};
    vecs[4] = '{"restart5",  2,  5, 16'hFFFF, 1'b1, 8};
    vecs[5] = '{"long20",    10, 20, 16'hFFFF, 1'b0, 23};
    vecs[6] = '{"mixed6",    5,  6, 16'h5A3C, 1'b0, 0};
    vecs[7] = '{"single1",   15, 1, 16'hFFFF, 1'b0, 4};

    #3;
    chk_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 8; v++)
      run_xfer(vecs[v].name, vecs[v].base, vecs[v].len, vecs[v].pat,
               vecs[v].restart, vecs[v].exp_done);

    // Reset in the middle of a 6-word transfer after two words accepted.
    pops = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      start        = (c == 0);
      base_addr    = 4'd0;
      length       = 5'd6;
      bus.OutReady = 1'b1;
      #1;
      if (bus.OutValid && bus.OutReady) pops++;
    end
    start = 1'b0;
    chk("midrst_pops_before", pops, 2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) mem[i] = 8'h30 + 8'(i);
    run_xfer("post_rst", 5, 3, 16'hFFFF, 1'b0, 6);

    for (int r = 0; r < 25; r++) begin
      logic [15:0] pat;
      for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
      pat = 16'($urandom) | 16'h0101;
      run_xfer($sformatf("rand%0d", r), int'($urandom_range(0, 15)),
               int'($urandom_range(0, 20)), pat, 1'($urandom_range(0, 1)), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
